// File: rtl/uart_core_p.sv
// uart_core_p: full-duplex UART with parametrised data width, parity, stop bits and oversampling.
// Latency: rx_valid rises 2 clk after the mid-stop sample point (2-flop sync + holding register); tx starts 1 clk after accept.
// Backpressure: tx_ready drops for the whole frame; an RX word held unaccepted at the next stop sample drops that frame and pulses rx_overrun.
//
// Ports:
//   clk, rst_n      core clock, asynchronous active-low reset
//   rx, tx          serial in (asynchronous, synchronised here) / serial out (registered, idle high)
//   rx_data/valid/ready, rx_parity_err, rx_frame_err  received word holding register and its flags
//   rx_overrun      one-clk pulse when a completed frame is dropped
//   rx_busy         receiver not idle
//   tx_data/valid/ready  transmit request handshake; tx_busy = transmitter not idle
module uart_core_p #(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic                 tx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_overrun,
  output logic                 rx_busy,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_busy
);

  localparam int DIV_RAW = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  localparam int OS_W  = 5;
  localparam int BIT_W = 4;
  localparam logic [OS_W-1:0]  OS_LAST   = OS_W'(OVERSAMPLE - 1);
  // Number of low ticks already counted when the mid start-bit tick arrives.
  localparam logic [OS_W-1:0]  HALF_LAST = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam logic             PAR_ODD   = (PARITY == 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // ---------------------------------------------------------------- RX path
  logic                 sync1_q, sync2_q;
  logic [DIV_W-1:0]     rdiv_q, rdiv_d;
  logic                 rx_tick;
  state_t               rx_state_q, rx_state_d;
  logic [OS_W-1:0]      rx_cnt_q, rx_cnt_d;
  logic [BIT_W-1:0]     rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                 rx_armed_q, rx_armed_d;
  logic                 rx_perr_q, rx_perr_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 rx_perr_out_q, rx_perr_out_d;
  logic                 rx_ferr_q, rx_ferr_d;
  logic                 rx_ovr_q, rx_ovr_d;
  logic                 rx_s;

  assign rx_s    = sync2_q;
  assign rx_tick = (rdiv_q == DIV_LAST);
  assign rdiv_d  = rx_tick ? '0 : rdiv_q + 1'b1;

  always_comb begin
    rx_state_d    = rx_state_q;
    rx_cnt_d      = rx_cnt_q;
    rx_bit_d      = rx_bit_q;
    rx_shift_d    = rx_shift_q;
    rx_armed_d    = rx_armed_q;
    rx_perr_d     = rx_perr_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = rx_valid_q;
    rx_perr_out_d = rx_perr_out_q;
    rx_ferr_d     = rx_ferr_q;
    rx_ovr_d      = 1'b0;

    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end

    case (rx_state_q)
      S_IDLE: begin
        if (rx_tick) begin
          if (!rx_armed_q) begin
            // After a break the line must be seen idle before a new start counts.
            if (rx_s) rx_armed_d = 1'b1;
          end else if (!rx_s) begin
            rx_state_d = S_START;
            rx_cnt_d   = OS_W'(1);
          end
        end
      end
      S_START: begin
        if (rx_tick) begin
          if (rx_s) begin
            rx_state_d = S_IDLE;
            rx_armed_d = 1'b1;
          end else if (rx_cnt_q == HALF_LAST) begin
            rx_state_d = S_DATA;
            rx_cnt_d   = '0;
            rx_bit_d   = '0;
          end else begin
            rx_cnt_d = rx_cnt_q + 1'b1;
          end
        end
      end
      S_DATA: begin
        if (rx_tick) begin
          if (rx_cnt_q == OS_LAST) begin
            rx_cnt_d   = '0;
            rx_shift_d = {rx_s, rx_shift_q[DATA_BITS-1:1]};
            if (rx_bit_q == DATA_LAST) begin
              rx_bit_d   = '0;
              rx_state_d = (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              rx_bit_d = rx_bit_q + 1'b1;
            end
          end else begin
            rx_cnt_d = rx_cnt_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (rx_tick) begin
          if (rx_cnt_q == OS_LAST) begin
            rx_cnt_d   = '0;
            rx_perr_d  = ((^rx_shift_q) ^ rx_s) != PAR_ODD;
            rx_state_d = S_STOP;
          end else begin
            rx_cnt_d = rx_cnt_q + 1'b1;
          end
        end
      end
      S_STOP: begin
        if (rx_tick) begin
          if (rx_cnt_q == OS_LAST) begin
            rx_cnt_d   = '0;
            rx_state_d = S_IDLE;
            rx_armed_d = rx_s;
            if (!rx_valid_q || rx_ready) begin
              rx_data_d     = rx_shift_q;
              rx_valid_d    = 1'b1;
              rx_perr_out_d = (PARITY != 0) ? rx_perr_q : 1'b0;
              rx_ferr_d     = !rx_s;
            end else begin
              rx_ovr_d = 1'b1;
            end
          end else begin
            rx_cnt_d = rx_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        rx_state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q       <= 1'b1;
      sync2_q       <= 1'b1;
      rdiv_q        <= '0;
      rx_state_q    <= S_IDLE;
      rx_cnt_q      <= '0;
      rx_bit_q      <= '0;
      rx_shift_q    <= '0;
      rx_armed_q    <= 1'b0;
      rx_perr_q     <= 1'b0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      rx_perr_out_q <= 1'b0;
      rx_ferr_q     <= 1'b0;
      rx_ovr_q      <= 1'b0;
    end else begin
      sync1_q       <= rx;
      sync2_q       <= sync1_q;
      rdiv_q        <= rdiv_d;
      rx_state_q    <= rx_state_d;
      rx_cnt_q      <= rx_cnt_d;
      rx_bit_q      <= rx_bit_d;
      rx_shift_q    <= rx_shift_d;
      rx_armed_q    <= rx_armed_d;
      rx_perr_q     <= rx_perr_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      rx_perr_out_q <= rx_perr_out_d;
      rx_ferr_q     <= rx_ferr_d;
      rx_ovr_q      <= rx_ovr_d;
    end
  end

  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign rx_parity_err = rx_perr_out_q;
  assign rx_frame_err  = rx_ferr_q;
  assign rx_overrun    = rx_ovr_q;
  assign rx_busy       = (rx_state_q != S_IDLE);

  // ---------------------------------------------------------------- TX path
  state_t               tx_state_q, tx_state_d;
  logic [DIV_W-1:0]     tdiv_q, tdiv_d;
  logic                 tx_tick;
  logic [OS_W-1:0]      tx_cnt_q, tx_cnt_d;
  logic [BIT_W-1:0]     tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_par_q, tx_par_d;
  logic                 tx_q, tx_d;
  logic                 tx_accept;

  assign tx_accept = (tx_state_q == S_IDLE) && tx_valid;
  // Divider is held at zero while idle so every frame starts on a clean bit boundary.
  assign tx_tick   = (tx_state_q != S_IDLE) && (tdiv_q == DIV_LAST);
  assign tdiv_d    = ((tx_state_q == S_IDLE) || tx_tick) ? '0 : tdiv_q + 1'b1;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_d       = tx_q;

    case (tx_state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (tx_accept) begin
          tx_shift_d = tx_data;
          tx_par_d   = (^tx_data) ^ PAR_ODD;
          tx_state_d = S_START;
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_d       = 1'b0;
        end
      end
      S_START: begin
        if (tx_tick) begin
          if (tx_cnt_q == OS_LAST) begin
            tx_cnt_d   = '0;
            tx_state_d = S_DATA;
            tx_d       = tx_shift_q[0];
          end else begin
            tx_cnt_d = tx_cnt_q + 1'b1;
          end
        end
      end
      S_DATA: begin
        if (tx_tick) begin
          if (tx_cnt_q == OS_LAST) begin
            tx_cnt_d = '0;
            if (tx_bit_q == DATA_LAST) begin
              tx_bit_d = '0;
              if (PARITY != 0) begin
                tx_state_d = S_PARITY;
                tx_d       = tx_par_q;
              end else begin
                tx_state_d = S_STOP;
                tx_d       = 1'b1;
              end
            end else begin
              tx_bit_d   = tx_bit_q + 1'b1;
              tx_shift_d = tx_shift_q >> 1;
              tx_d       = tx_shift_q[1];
            end
          end else begin
            tx_cnt_d = tx_cnt_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (tx_tick) begin
          if (tx_cnt_q == OS_LAST) begin
            tx_cnt_d   = '0;
            tx_bit_d   = '0;
            tx_state_d = S_STOP;
            tx_d       = 1'b1;
          end else begin
            tx_cnt_d = tx_cnt_q + 1'b1;
          end
        end
      end
      S_STOP: begin
        tx_d = 1'b1;
        if (tx_tick) begin
          if (tx_cnt_q == OS_LAST) begin
            tx_cnt_d = '0;
            if (tx_bit_q == STOP_LAST) begin
              tx_bit_d   = '0;
              tx_state_d = S_IDLE;
            end else begin
              tx_bit_d = tx_bit_q + 1'b1;
            end
          end else begin
            tx_cnt_d = tx_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        tx_state_d = S_IDLE;
        tx_d       = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= S_IDLE;
      tdiv_q     <= '0;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tdiv_q     <= tdiv_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      tx_q       <= tx_d;
    end
  end

  assign tx       = tx_q;
  assign tx_ready = (tx_state_q == S_IDLE);
  assign tx_busy  = (tx_state_q != S_IDLE);

endmodule
